sha256_round_ctrl: RTL and testbench



---
 rtl/sha256_round_ctrl.sv | 106 ++++++++++
 tb/tb_sha256_round_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: loads a 16-word block, runs the sha-256 rounds and adds the chaining value into digest
module sha256_round_ctrl #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] hash_in,
  input  logic [31:0]  word_in,
  input  logic         word_valid,
  output logic         word_ready,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest
);
  typedef enum logic [1:0] {IDLE, LOAD, ROUND, FINAL} state_t;
  localparam logic [31:0] k_rom [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  state_t       state;
  logic [3:0]   wcnt;
  logic [5:0]   t;
  logic [255:0] chain;
  logic [31:0]  wbuf [16];
  logic [31:0]  v [8];
  logic [31:0]  w_sched, w, t1, t2;
  always_comb begin
    w_sched = ssig1(wbuf[t[3:0] - 4'd2]) + wbuf[t[3:0] - 4'd7] + ssig0(wbuf[t[3:0] - 4'd15]) + wbuf[t[3:0]];
    w = (t[5:4] == 2'b00) ? wbuf[t[3:0]] : w_sched;
    t1 = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k_rom[t] + w;
    t2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wcnt       <= '0;
      t          <= '0;
      word_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      digest     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          chain      <= hash_in;
          for (int i = 0; i < 8; i++) v[i] <= hash_in[255 - 32*i -: 32];
          wcnt       <= '0;
          word_ready <= 1'b1;
          busy       <= 1'b1;
          state      <= LOAD;
        end
        LOAD: if (word_valid) begin
          wbuf[wcnt] <= word_in;
          wcnt       <= wcnt + 1'b1;
          if (wcnt == 4'd15) begin
            word_ready <= 1'b0;
            t          <= '0;
            state      <= ROUND;
          end
        end
        ROUND: begin
          if (t[5:4] != 2'b00) wbuf[t[3:0]] <= w_sched;
          v[0] <= t1 + t2;
          v[1] <= v[0];
          v[2] <= v[1];
          v[3] <= v[2];
          v[4] <= v[3] + t1;
          v[5] <= v[4];
          v[6] <= v[5];
          v[7] <= v[6];
          t    <= t + 1'b1;
          if (t == 6'(NUM_ROUNDS - 1)) state <= FINAL;
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) digest[255 - 32*i -: 32] <= chain[255 - 32*i -: 32] + v[i];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb_sha256_round_ctrl: checks sha256_round_ctrl against a block-level sha-256 model and known digests
module tb_sha256_round_ctrl;
  localparam int NR = 64;
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [31:0] kk [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, word_valid = 1'b0;
  logic [255:0] hash_in = '0;
  logic [31:0] word_in = '0;
  logic word_ready, busy, done;
  logic [255:0] digest;
  int total = 0, bad = 0, cyc = 0, t_start = 0, e0 = 0;
  logic chk_en = 1'b0;
  logic [31:0] blk [16];
  sha256_round_ctrl #(.NUM_ROUNDS(NR)) dut (
    .clk(clk), .rst(rst), .start(start), .hash_in(hash_in), .word_in(word_in),
    .word_valid(word_valid), .word_ready(word_ready), .busy(busy), .done(done), .digest(digest)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d = {x, x} >> n;
    return d[31:0];
  endfunction
  function automatic logic [255:0] compress(input logic [255:0] h, input logic [31:0] m [16]);
    logic [31:0] w [64];
    logic [31:0] s [8];
    logic [31:0] x, y;
    logic [255:0] r;
    for (int i = 0; i < 64; i++)
      w[i] = i < 16 ? m[i] : (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                             + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) s[i] = h[255 - 32*i -: 32];
    for (int i = 0; i < NR; i++) begin
      x = s[7] + (rr(s[4], 6) ^ rr(s[4], 11) ^ rr(s[4], 25)) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + kk[i] + w[i];
      y = (rr(s[0], 2) ^ rr(s[0], 13) ^ rr(s[0], 22)) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      for (int j = 7; j > 0; j--) s[j] = s[j-1];
      s[4] = s[4] + x;
      s[0] = x + y;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = h[255 - 32*i -: 32] + s[i];
    return r;
  endfunction
  int mphase = 0, mcnt = 0;
  logic [31:0] mw [16];
  logic [255:0] mh;
  logic exp_ready, exp_busy, exp_done;
  logic [255:0] exp_dig;
  always @(posedge clk) begin
    if (rst) begin
      mphase = 0;
      mcnt = 0;
      exp_done = 1'b0;
      exp_dig = '0;
    end else begin
      exp_done = 1'b0;
      if (mphase == 0 && start) begin
        mphase = 1;
        mh = hash_in;
        mcnt = 0;
      end else if (mphase == 1 && word_valid) begin
        mw[mcnt] = word_in;
        mcnt++;
        if (mcnt == 16) begin
          mphase = 2;
          mcnt = 0;
        end
      end else if (mphase == 2) begin
        mcnt++;
        if (mcnt == NR + 1) begin
          exp_dig = compress(mh, mw);
          exp_done = 1'b1;
          mphase = 0;
        end
      end
    end
    exp_ready = mphase == 1;
    exp_busy = mphase != 0;
  end
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("word_ready", {255'd0, word_ready}, {255'd0, exp_ready});
    chk("busy", {255'd0, busy}, {255'd0, exp_busy});
    chk("done", {255'd0, done}, {255'd0, exp_done});
    chk("digest", digest, exp_dig);
  end
  task automatic send_block(input logic [255:0] h, input logic gaps);
    start = 1'b1;
    hash_in = h;
    @(negedge clk);
    start = 1'b0;
    t_start = cyc;
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        word_valid = 1'b0;
        repeat ($urandom_range(0, 5)) @(negedge clk);
      end
      word_valid = 1'b1;
      word_in = blk[i];
      @(negedge clk);
    end
    word_valid = 1'b0;
    e0 = cyc;
  endtask
  task automatic wait_done();
    int n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 256'd0, 256'd1);
  endtask
  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0] = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask
  task automatic set_empty();
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0] = 32'h80000000;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_digest", digest, 256'd0);
    chk("reset_busy", {255'd0, busy}, 256'd0);
    rst = 1'b0;
    @(negedge clk);
    set_abc();
    send_block(IV, 1'b0);
    wait_done();
    chk("abc_latency", 256'(cyc - e0), 256'd65);
    chk("abc_digest", digest, ABC);
    @(negedge clk);
    set_empty();
    send_block(IV, 1'b0);
    wait_done();
    chk("empty_digest", digest, EMPTY);
    @(negedge clk);
    set_abc();
    send_block(IV, 1'b1);
    wait_done();
    chk("gap_latency", 256'(cyc - e0), 256'd65);
    chk("gap_digest", digest, ABC);
    @(negedge clk);
    send_block(IV, 1'b0);
    repeat (10) @(negedge clk);
    start = 1'b1;
    hash_in = '1;
    word_valid = 1'b1;
    word_in = 32'hdeadbeef;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("ignore_digest", digest, ABC);
    repeat (70) @(negedge clk);
    chk("ignore_idle_busy", {255'd0, busy}, 256'd0);
    word_valid = 1'b0;
    @(negedge clk);
    set_empty();
    send_block(IV, 1'b0);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_digest", digest, 256'd0);
    chk("midrst_busy", {255'd0, busy}, 256'd0);
    rst = 1'b0;
    @(negedge clk);
    send_block(IV, 1'b0);
    wait_done();
    chk("after_rst_digest", digest, EMPTY);
    @(negedge clk);
    set_abc();
    send_block(IV, 1'b0);
    wait_done();
    chk("b2b_first_digest", digest, ABC);
    send_block(ABC, 1'b0);
    wait_done();
    chk("b2b_latency", 256'(cyc - t_start), 256'd81);
    chk("b2b_digest", digest, compress(ABC, blk));
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
